// File: rtl/hms_timekeeper.sv
// Hours/minutes/seconds timekeeper with 1 Hz prescaler, run/pause, validated load,
// single alarm and day-rollover strobe. All outputs are registered.
module hms_timekeeper #(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       load_valid,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic       alarm_wr,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_en,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       day_pulse,
  output logic       alarm_pulse,
  output logic       load_err
);

  localparam int              PW         = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0]      HOUR_LAST  = 5'(HOUR_MAX);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_q, day_d;
  logic          alarm_q, alarm_d;
  logic          err_q, err_d;
  logic [4:0]    alarm_hh_q, alarm_hh_d;
  logic [5:0]    alarm_mm_q, alarm_mm_d;

  logic tick, load_ok, wrap_min, wrap_hr, wrap_day;

  always_comb begin
    tick     = run_en && (presc_q == PRESC_LAST);
    load_ok  = load_valid && (load_hh <= HOUR_LAST) && (load_mm <= 6'd59) && (load_ss <= 6'd59);
    wrap_min = (sec_q == 6'd59);
    wrap_hr  = wrap_min && (min_q == 6'd59);
    wrap_day = wrap_hr && (hours_q == HOUR_LAST);

    presc_d    = presc_q;
    hours_d    = hours_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_d      = 1'b0;
    alarm_d    = 1'b0;
    err_d      = load_valid && !load_ok;
    alarm_hh_d = alarm_wr ? alarm_hh : alarm_hh_q;
    alarm_mm_d = alarm_wr ? alarm_mm : alarm_mm_q;

    // A valid load wins over a coincident tick; the tick is simply lost.
    if (load_ok) begin
      presc_d = '0;
      hours_d = load_hh;
      min_d   = load_mm;
      sec_d   = load_ss;
    end else if (tick) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      day_d      = wrap_day;
      sec_d      = wrap_min ? 6'd0 : sec_q + 6'd1;
      if (wrap_min) min_d = wrap_hr ? 6'd0 : min_q + 6'd1;
      if (wrap_hr)  hours_d = wrap_day ? 5'd0 : hours_q + 5'd1;
      // Compare against the alarm registers as they stand before any coincident write.
      alarm_d = alarm_en && (hours_d == alarm_hh_q) && (min_d == alarm_mm_q) && (sec_d == 6'd0);
    end else if (run_en) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      hours_q    <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      day_q      <= 1'b0;
      alarm_q    <= 1'b0;
      err_q      <= 1'b0;
      alarm_hh_q <= '0;
      alarm_mm_q <= '0;
    end else begin
      presc_q    <= presc_d;
      hours_q    <= hours_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_q      <= day_d;
      alarm_q    <= alarm_d;
      err_q      <= err_d;
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
    end
  end

  assign hours       = hours_q;
  assign minutes     = min_q;
  assign seconds     = sec_q;
  assign sec_tick    = sec_tick_q;
  assign day_pulse   = day_q;
  assign alarm_pulse = alarm_q;
  assign load_err    = err_q;

endmodule
